// File: rtl/fft_mag_reader.sv
// fft_mag_reader: sweeps the FFT result RAM bin by bin and emits an
// alpha-max-plus-beta-min magnitude estimate (max + min/2) per bin over a
// valid/ready handshake. One bin takes four cycles: ADDR, WAIT, CALC, HOLD.
module fft_mag_reader #(
  parameter int NUM_BINS = 512,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramRe,
  input  logic [DATA_W-1:0] DinR,
  input  logic [DATA_W-1:0] DinI,
  output logic [DATA_W-1:0] magOut,
  output logic [ADDR_W-1:0] binIdx,
  output logic              magValid,
  input  logic              magReady
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_ADDR = 6'b000010,
    S_WAIT = 6'b000100,
    S_CALC = 6'b001000,
    S_HOLD = 6'b010000,
    S_FIN  = 6'b100000
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_dr, r_di;
  logic [DATA_W-1:0] r_mag;
  logic [ADDR_W-1:0] r_bin;
  logic              r_valid;

  logic [DATA_W-1:0] w_absr, w_absi, w_max, w_min, w_mag;
  logic              w_last;

  // Unsigned DATA_W-bit magnitudes: the most negative input maps to 2^(DATA_W-1)
  // exactly, and max + min/2 stays below 2^DATA_W, so no saturation is needed.
  assign w_absr = r_dr[DATA_W-1] ? (~r_dr + 1'b1) : r_dr;
  assign w_absi = r_di[DATA_W-1] ? (~r_di + 1'b1) : r_di;
  assign w_max  = (w_absr >= w_absi) ? w_absr : w_absi;
  assign w_min  = (w_absr >= w_absi) ? w_absi : w_absr;
  assign w_mag  = w_max + (w_min >> 1);
  assign w_last = (r_idx == ADDR_W'(NUM_BINS - 1));

  assign ramAddr  = r_idx;
  assign magOut   = r_mag;
  assign binIdx   = r_bin;
  assign magValid = r_valid;

  // State register; reset wins over start on the same edge.
  always_ff @(posedge Clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and state-decoded outputs; all outputs come from registers only.
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    ramRe  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_ADDR;
      end
      S_ADDR: begin
        ramRe  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: w_next = S_CALC;
      S_CALC: w_next = S_HOLD;
      S_HOLD: if (magReady) w_next = w_last ? S_FIN : S_ADDR;
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: bin counter, RAM data capture in WAIT (the only cycle the RAM
  // guarantees it), magnitude register loaded in CALC and held through HOLD.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_dr    <= '0;
      r_di    <= '0;
      r_mag   <= '0;
      r_bin   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_idx <= '0;
        S_WAIT: begin
          r_dr <= DinR;
          r_di <= DinI;
        end
        S_CALC: begin
          r_mag   <= w_mag;
          r_bin   <= r_idx;
          r_valid <= 1'b1;
        end
        S_HOLD: begin
          if (magReady) begin
            r_valid <= 1'b0;
            if (!w_last) r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
